// File: rtl/host_ctrl.sv
// SUMP host-protocol controller: parses short/long commands from the RXD byte stream,
// answers the ID query and serialises MDW-wide memory words into kept TXD bytes.
module host_ctrl #(
    parameter int          MDW = 32,
    parameter int          TMO = 5_000_000,
    parameter logic [31:0] ID  = 32'h534c4131
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             str_rxd_tvalid,
    input  logic [7:0]       str_rxd_tdata,
    output logic             str_rxd_tready,
    output logic [7:0]       cmd_code,
    output logic [31:0]      cmd_data,
    output logic             cmd_valid,
    input  logic             mem_tvalid,
    input  logic [MDW-1:0]   mem_tdata,
    input  logic [MDW/8-1:0] mem_tkeep,
    input  logic             mem_tlast,
    output logic             mem_tready,
    output logic             str_txd_tvalid,
    output logic [7:0]       str_txd_tdata,
    input  logic             str_txd_tready,
    output logic             busy,
    output logic             err_timeout
);

    localparam int NB = MDW / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW = $clog2(TMO + 1);

    typedef enum logic {RX_IDLE, RX_ARG} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_ID, TX_WORD} tx_state_e;

    // ---------------- receive side ----------------
    rx_state_e     rx_state_q;
    logic          run_q;
    logic [7:0]    op_q;
    logic [31:0]   arg_q;
    logic [1:0]    cnt_q;
    logic [TW-1:0] tmr_q;
    logic [7:0]    cmd_code_q;
    logic [31:0]   cmd_data_q;
    logic          cmd_valid_q;
    logic          err_q;

    logic rx_fire;
    logic id_set;
    logic abort_now;

    assign rx_fire   = str_rxd_tvalid & run_q;
    assign id_set    = rx_fire && (rx_state_q == RX_IDLE) && (str_rxd_tdata == 8'h02);
    assign abort_now = cmd_valid_q && (cmd_code_q == 8'h00);

    // NOTE: sequential state is only ever written with <= so every block sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q  <= RX_IDLE;
            run_q       <= 1'b0;
            op_q        <= '0;
            arg_q       <= '0;
            cnt_q       <= '0;
            tmr_q       <= '0;
            cmd_code_q  <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_fire) begin
                        if (!str_rxd_tdata[7]) begin
                            cmd_code_q  <= str_rxd_tdata;
                            cmd_data_q  <= '0;
                            cmd_valid_q <= 1'b1;
                        end else begin
                            op_q       <= str_rxd_tdata;
                            cnt_q      <= '0;
                            tmr_q      <= '0;
                            rx_state_q <= RX_ARG;
                        end
                    end
                end
                RX_ARG: begin
                    if (rx_fire) begin
                        tmr_q                <= '0;
                        cnt_q                <= cnt_q + 2'd1;
                        arg_q[8*cnt_q +: 8]  <= str_rxd_tdata;
                        if (cnt_q == 2'd3) begin
                            cmd_code_q  <= op_q;
                            cmd_data_q  <= {str_rxd_tdata, arg_q[23:0]};
                            cmd_valid_q <= 1'b1;
                            rx_state_q  <= RX_IDLE;
                        end
                    end else if (tmr_q == TW'(TMO - 1)) begin
                        // The partial argument is dropped; cmd_code/cmd_data keep the last command.
                        err_q      <= 1'b1;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // ---------------- transmit side ----------------
    tx_state_e      tx_state_q;
    logic [MDW-1:0] word_q;
    logic [NB-1:0]  keep_q;
    logic           last_q;
    logic [2:0]     id_idx_q;
    logic           txd_valid_q;
    logic [7:0]     txd_data_q;
    logic           busy_q;
    logic           rd_act_q;
    logic           id_pend_q;
    logic           abort_q;

    logic          abort;
    logic          txd_fire;
    logic          mem_fire;
    logic [IW-1:0] new_idx;
    logic [IW-1:0] nxt_idx;

    function automatic logic [IW-1:0] lowest(input logic [NB-1:0] k);
        lowest = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (k[i]) lowest = IW'(i);
        end
    endfunction

    assign abort    = abort_now | abort_q;
    assign txd_fire = txd_valid_q & str_txd_tready;
    // NOTE: mem_tready is combinational so a waiting word is taken in the same IDLE cycle.
    assign mem_fire = run_q && (tx_state_q == TX_IDLE) && !id_pend_q && !abort && mem_tvalid;
    assign new_idx  = lowest(mem_tkeep);
    assign nxt_idx  = lowest(keep_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q  <= TX_IDLE;
            word_q      <= '0;
            keep_q      <= '0;
            last_q      <= 1'b0;
            id_idx_q    <= '0;
            txd_valid_q <= 1'b0;
            txd_data_q  <= '0;
            busy_q      <= 1'b0;
            rd_act_q    <= 1'b0;
            id_pend_q   <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            if (abort) begin
                // A byte already on the bus must finish its handshake before the drop.
                if (txd_valid_q && !str_txd_tready) begin
                    abort_q <= 1'b1;
                end else begin
                    abort_q     <= 1'b0;
                    txd_valid_q <= 1'b0;
                    tx_state_q  <= TX_IDLE;
                    busy_q      <= 1'b0;
                    rd_act_q    <= 1'b0;
                end
            end else begin
                case (tx_state_q)
                    TX_IDLE: begin
                        if (id_pend_q) begin
                            id_pend_q   <= 1'b0;
                            txd_valid_q <= 1'b1;
                            txd_data_q  <= ID[7:0];
                            id_idx_q    <= 3'd1;
                            busy_q      <= 1'b1;
                            tx_state_q  <= TX_ID;
                        end else if (mem_fire) begin
                            word_q      <= mem_tdata;
                            last_q      <= mem_tlast;
                            keep_q      <= mem_tkeep & ~(NB'(1) << new_idx);
                            txd_valid_q <= |mem_tkeep;
                            if (|mem_tkeep) txd_data_q <= mem_tdata[8*new_idx +: 8];
                            busy_q      <= 1'b1;
                            rd_act_q    <= !mem_tlast;
                            tx_state_q  <= TX_WORD;
                        end
                    end
                    TX_ID: begin
                        if (txd_fire) begin
                            if (id_idx_q == 3'd4) begin
                                txd_valid_q <= 1'b0;
                                busy_q      <= rd_act_q;
                                tx_state_q  <= TX_IDLE;
                            end else begin
                                txd_data_q <= ID[8*id_idx_q +: 8];
                                id_idx_q   <= id_idx_q + 3'd1;
                            end
                        end
                    end
                    TX_WORD: begin
                        if (!txd_valid_q || txd_fire) begin
                            if (|keep_q) begin
                                txd_data_q  <= word_q[8*nxt_idx +: 8];
                                txd_valid_q <= 1'b1;
                                keep_q      <= keep_q & ~(NB'(1) << nxt_idx);
                            end else begin
                                txd_valid_q <= 1'b0;
                                tx_state_q  <= TX_IDLE;
                                if (last_q) busy_q <= 1'b0;
                            end
                        end
                    end
                    default: tx_state_q <= TX_IDLE;
                endcase
            end
            // A fresh ID query wins over the clears above.
            if (abort_now) id_pend_q <= 1'b0;
            if (id_set)    id_pend_q <= 1'b1;
        end
    end

    assign str_rxd_tready = run_q;
    assign cmd_code       = cmd_code_q;
    assign cmd_data       = cmd_data_q;
    assign cmd_valid      = cmd_valid_q;
    assign err_timeout    = err_q;
    assign mem_tready     = mem_fire;
    assign str_txd_tvalid = txd_valid_q;
    assign str_txd_tdata  = txd_data_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_host_ctrl.sv
// Directed bench for host_ctrl: scoreboard queues for commands and TXD bytes,
// compared by a negedge monitor, plus cycle-exact checks in the main sequence.
module tb_host_ctrl;

    localparam int MDW = 32;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           str_rxd_tvalid = 1'b0;
    logic [7:0]     str_rxd_tdata = '0;
    logic           str_rxd_tready;
    logic [7:0]     cmd_code;
    logic [31:0]    cmd_data;
    logic           cmd_valid;
    logic           mem_tvalid = 1'b0;
    logic [MDW-1:0] mem_tdata = '0;
    logic [3:0]     mem_tkeep = '0;
    logic           mem_tlast = 1'b0;
    logic           mem_tready;
    logic           str_txd_tvalid;
    logic [7:0]     str_txd_tdata;
    logic           str_txd_tready = 1'b0;
    logic           busy;
    logic           err_timeout;

    host_ctrl #(.MDW(MDW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .str_rxd_tvalid(str_rxd_tvalid), .str_rxd_tdata(str_rxd_tdata), .str_rxd_tready(str_rxd_tready),
        .cmd_code(cmd_code), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .mem_tvalid(mem_tvalid), .mem_tdata(mem_tdata), .mem_tkeep(mem_tkeep), .mem_tlast(mem_tlast),
        .mem_tready(mem_tready),
        .str_txd_tvalid(str_txd_tvalid), .str_txd_tdata(str_txd_tdata), .str_txd_tready(str_txd_tready),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         rdy_mode = 1;   // 0 = low, 1 = high, 2 = random
    bit         mon_en  = 1'b0;
    bit         stall_q = 1'b0;
    logic [7:0] stall_d = '0;
    logic [7:0]  txq[$];
    logic [39:0] cmdq[$];
    int          hs_cyc[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       str_txd_tready = 1'b0;
            1:       str_txd_tready = 1'b1;
            default: str_txd_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: inputs change just after posedge, so negedge values are those seen at the next edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_q) begin
                check("txd_hold_valid", 64'(str_txd_tvalid), 64'd1);
                check("txd_hold_data", 64'(str_txd_tdata), 64'(stall_d));
            end
            stall_q = str_txd_tvalid && !str_txd_tready;
            stall_d = str_txd_tdata;
            if (str_txd_tvalid && str_txd_tready) begin
                check("txd_byte_expected", 64'(txq.size() != 0), 64'd1);
                if (txq.size() != 0) check("txd_byte", 64'(str_txd_tdata), 64'(txq.pop_front()));
                hs_cyc.push_back(cyc);
            end
            if (cmd_valid) begin
                check("cmd_expected", 64'(cmdq.size() != 0), 64'd1);
                if (cmdq.size() != 0) check("cmd", 64'({cmd_code, cmd_data}), 64'(cmdq.pop_front()));
            end
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) align();
    endtask

    task automatic send_rx(input logic [7:0] b);
        bit got = 1'b0;
        str_rxd_tvalid = 1'b1;
        str_rxd_tdata  = b;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (str_rxd_tready) begin
                got = 1'b1;
                break;
            end
        end
        check("rxd_accept", 64'(got), 64'd1);
        align();
        str_rxd_tvalid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic last, input bit push);
        bit got = 1'b0;
        if (push) begin
            for (int i = 0; i < 4; i++) if (k[i]) txq.push_back(d[8*i +: 8]);
        end
        mem_tvalid = 1'b1;
        mem_tdata  = d;
        mem_tkeep  = k;
        mem_tlast  = last;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (mem_tready) begin
                got = 1'b1;
                break;
            end
        end
        check("mem_accept", 64'(got), 64'd1);
        align();
        mem_tvalid = 1'b0;
    endtask

    task automatic drain_tx();
        for (int c = 0; c < 2000 && txq.size() != 0; c++) @(posedge clk);
        check("tx_drain", 64'(txq.size()), 64'd0);
        @(negedge clk);
    endtask

    function automatic logic [53:0] outs();
        return {str_rxd_tready, cmd_valid, mem_tready, str_txd_tvalid, busy, err_timeout,
                str_txd_tdata, cmd_code, cmd_data};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] lc[5];
        // ---- reset state (mem_tvalid high to show mem_tready is held off) ----
        mem_tvalid = 1'b1;
        #2 rst = 1'b0;
        #1 check("reset_outputs", 64'(outs()), 64'd0);
        repeat (2) @(negedge clk);
        check("reset_outputs_held", 64'(outs()), 64'd0);
        mem_tvalid = 1'b0;
        rst = 1'b1;
        #1 check("rxd_ready_before_edge", 64'(str_rxd_tready), 64'd0);
        @(negedge clk);
        check("rxd_ready_after_release", 64'(str_rxd_tready), 64'd1);
        align();
        mon_en = 1'b1;

        // ---- short command ----
        cmdq.push_back({8'h01, 32'h0});
        send_rx(8'h01);
        @(negedge clk);
        check("short_strobe", 64'({cmd_valid, cmd_code, cmd_data}), 64'({1'b1, 8'h01, 32'h0}));
        @(negedge clk);
        check("short_strobe_one_cycle", 64'(cmd_valid), 64'd0);
        align();

        // ---- long command with random gaps ----
        lc = '{8'hC0, 8'h78, 8'h56, 8'h34, 8'h12};
        cmdq.push_back({8'hC0, 32'h12345678});
        for (int i = 0; i < 5; i++) begin
            send_rx(lc[i]);
            idle($urandom_range(0, 3));
        end
        idle(5);
        check("long_cmd_seen", 64'(cmdq.size()), 64'd0);
        check("long_cmd_hold", 64'({cmd_code, cmd_data}), 64'({8'hC0, 32'h12345678}));

        // ---- timeout ----
        send_rx(8'h80);
        send_rx(8'hAA);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("timeout_not_early", 64'(err_timeout), 64'd0);
        @(negedge clk);
        check("timeout_pulse", 64'(err_timeout), 64'd1);
        @(negedge clk);
        check("timeout_one_cycle", 64'(err_timeout), 64'd0);
        check("timeout_keeps_cmd", 64'({cmd_code, cmd_data}), 64'({8'hC0, 32'h12345678}));
        align();
        cmdq.push_back({8'h01, 32'h0});
        send_rx(8'h01);
        idle(3);
        check("after_timeout_cmd", 64'(cmdq.size()), 64'd0);

        // ---- ID reply ahead of a waiting word, random TXD backpressure ----
        rdy_mode = 2;
        txq.push_back(8'h31); txq.push_back(8'h41); txq.push_back(8'h4C); txq.push_back(8'h53);
        cmdq.push_back({8'h02, 32'h0});
        send_rx(8'h02);
        send_word(32'h0D0C0B0A, 4'b1111, 1'b1, 1'b1);
        @(negedge clk);
        check("id_word_busy", 64'(busy), 64'd1);
        drain_tx();
        check("id_word_busy_clear", 64'(busy), 64'd0);
        align();

        // ---- keep packing, one byte per cycle ----
        rdy_mode = 1;
        idle(2);
        hs_cyc.delete();
        send_word(32'hDDCCBBAA, 4'b1010, 1'b0, 1'b1);
        send_word(32'h44332211, 4'b0000, 1'b0, 1'b1);
        check("pack_busy_mid", 64'(busy), 64'd1);
        send_word(32'h88776655, 4'b1111, 1'b1, 1'b1);
        drain_tx();
        check("pack_busy_clear", 64'(busy), 64'd0);
        check("pack_byte_count", 64'(hs_cyc.size()), 64'd6);
        if (hs_cyc.size() == 6) begin
            check("pack_b2b_0", 64'(hs_cyc[1] - hs_cyc[0]), 64'd1);
            check("pack_b2b_2", 64'(hs_cyc[3] - hs_cyc[2]), 64'd1);
            check("pack_b2b_3", 64'(hs_cyc[4] - hs_cyc[3]), 64'd1);
            check("pack_b2b_4", 64'(hs_cyc[5] - hs_cyc[4]), 64'd1);
        end
        align();

        // ---- reset command mid-word ----
        rdy_mode = 0;
        idle(2);
        txq.push_back(8'hAA);
        send_word(32'hDDCCBBAA, 4'b1111, 1'b0, 1'b0);
        @(negedge clk);
        check("abort_presented", 64'({str_txd_tvalid, busy, str_txd_tdata}), 64'({1'b1, 1'b1, 8'hAA}));
        align();
        cmdq.push_back({8'h00, 32'h0});
        send_rx(8'h00);
        idle(4);
        rdy_mode = 1;
        idle(10);
        @(negedge clk);
        check("abort_inflight_done", 64'(txq.size()), 64'd0);
        check("abort_idle", 64'({str_txd_tvalid, busy}), 64'd0);
        align();

        // ---- asynchronous reset mid-long-command and mid-word ----
        rdy_mode = 0;
        idle(2);
        send_word(32'h11223344, 4'b1111, 1'b1, 1'b0);
        send_rx(8'h80);
        send_rx(8'h11);
        mem_tvalid = 1'b1;
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1 check("async_reset_outputs", 64'(outs()), 64'd0);
        txq.delete();
        cmdq.delete();
        mem_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("recover_rxd_ready", 64'(str_rxd_tready), 64'd1);
        align();
        mon_en = 1'b1;
        rdy_mode = 1;
        cmdq.push_back({8'hC1, 32'h01020304});
        send_rx(8'hC1); send_rx(8'h04); send_rx(8'h03); send_rx(8'h02); send_rx(8'h01);
        send_word(32'h000000EE, 4'b0001, 1'b1, 1'b1);
        drain_tx();
        check("recover_busy", 64'(busy), 64'd0);
        idle(3);
        check("recover_cmd", 64'(cmdq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/host_ctrl.md
Name: host_ctrl

Overview:
- Host-protocol controller between the UART byte streams and the analyzer core. Generalised successor of the fixed 32-bit control path.
- Receive side: parses SUMP short (1-byte) and long (5-byte) commands from the RXD stream into cmd_code/cmd_data/cmd_valid. A partial long command is abandoned after a timeout.
- Transmit side: answers the ID query and serialises MDW-wide captured memory words into TXD bytes, sending only bytes whose keep bit is set.

Parameters:
- MDW, 32, memory word width; a multiple of 8, range 8..128.
- TMO, 5_000_000, idle cycles allowed between bytes of a long command before it is abandoned; must be >= 1.
- ID, 32'h534c4131, ID reply; sent LSB byte first, so the host receives "1ALS".

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- str_rxd_tvalid  in  1  RXD byte valid.
- str_rxd_tdata  in  8  RXD byte.
- str_rxd_tready  out  1  RXD byte accept.
- cmd_code  out  8  command opcode.
- cmd_data  out  32  command argument.
- cmd_valid  out  1  one-cycle command strobe.
- mem_tvalid  in  1  memory word valid.
- mem_tdata  in  MDW  memory word.
- mem_tkeep  in  MDW/8  per-byte enable; bit i covers byte [8i+7:8i].
- mem_tlast  in  1  last word of the readout.
- mem_tready  out  1  memory word accept.
- str_txd_tvalid  out  1  TXD byte valid.
- str_txd_tdata  out  8  TXD byte.
- str_txd_tready  in  1  TXD byte accept.
- busy  out  1  high while a readout or ID reply is in progress.
- err_timeout  out  1  one-cycle pulse when a partial long command is dropped.

Behaviour:
- Reset (rst=0, asynchronous): both FSMs go to IDLE. All outputs are 0, including str_rxd_tready, str_txd_tdata, cmd_code and cmd_data. Counters and ID-pending are cleared. In the first cycle after release, str_rxd_tready=1 and stays 1 thereafter.
- Handshakes: a transfer occurs when valid and ready are both high on a rising edge. Once str_txd_tvalid is asserted, it and str_txd_tdata hold until accepted; they are never withdrawn.
- RX FSM states: IDLE, ARG.
- IDLE, byte b accepted with b[7]=0 (short command):
  - cmd_code=b and cmd_data=0 are registered.
  - cmd_valid pulses high on the next cycle.
  - If b=8'h02, ID-pending is also set.
- IDLE, byte b accepted with b[7]=1 (long command):
  - b is latched as the opcode; go to ARG; cnt=0; idle timer=0.
- ARG:
  - Each accepted byte is placed at cmd_data[8*cnt+7:8*cnt] (argument is little-endian) and cnt increments.
  - On the 4th byte: cmd_code and cmd_data update together, cmd_valid pulses on the next cycle, and the FSM returns to IDLE.
  - The idle timer increments on each cycle with no accepted byte and resets on each accepted byte.
  - Timer reaching TMO: return to IDLE, pulse err_timeout one cycle, no cmd_valid. cmd_code/cmd_data keep their previous values.
- Between strobes, cmd_code/cmd_data hold their last values.
- TX FSM states: IDLE, ID, WORD.
- TX IDLE:
  - If ID-pending: clear it, go to ID, idx=0. The ID reply has priority over a waiting memory word.
  - Else if mem_tvalid: assert mem_tready for exactly that cycle, latch data/keep/last, go to WORD.
  - mem_tready is otherwise 0.
- TX ID: send ID bytes 0..3 in order, then return to IDLE.
- TX WORD:
  - Send the bytes with keep=1 in ascending index order; disabled bytes are skipped with zero bubble cycles.
  - Consecutive kept bytes are presented back-to-back; one byte per cycle when str_txd_tready is held high.
  - After the last kept byte is accepted, return to IDLE.
  - A word with keep all-zero is consumed and produces no bytes; one cycle in WORD, then IDLE.
- busy:
  - Set on any word accept or on entry to ID.
  - Cleared when the final byte of a word latched with tlast=1 is accepted, or when an ID reply completes with no readout active.
  - A keep=0 tlast word clears busy on its WORD exit cycle.
- Reset command (short 8'h00 decoded):
  - Clears ID-pending.
  - Aborts TX: a byte already presented completes its handshake; the remaining bytes of the word are discarded; the FSM goes to IDLE and busy clears.
  - The abort takes effect on the cycle cmd_valid is strobed.
- Simultaneous RX command decode and TX activity are independent. An ID query received during a readout is queued and sent after the current word.

Test Plan:
- Short command: RXD 8'h01 -> one cycle later cmd_valid=1 for 1 cycle, cmd_code=8'h01, cmd_data=0.
- Long command: RXD 8'hC0,8'h78,8'h56,8'h34,8'h12 with random 0-3 gaps -> single cmd_valid, cmd_code=8'hC0, cmd_data=32'h12345678.
- Timeout: TMO=16, RXD 8'h80,8'hAA then 16 idle cycles -> err_timeout pulse, no cmd_valid. A following 8'h01 decodes normally.
- ID reply: RXD 8'h02 while a memory word is waiting -> TXD 8'h31,8'h41,8'h4C,8'h53, then the memory bytes. Check with str_txd_tready toggling randomly; tvalid/tdata stable while stalled.
- Keep packing: MDW=32, words {32'hDDCCBBAA keep 4'b1010}, {32'h44332211 keep 4'b0000}, {32'h88776655 keep 4'b1111, tlast} -> TXD BB,DD,55,66,77,88 exactly. busy falls after 88 is accepted.
- Abort/reset: 8'h00 received mid-word -> in-flight byte completes, no further bytes, busy=0. Asserting rst mid-long-command and mid-word -> all outputs 0 immediately, clean recovery after release.
